// File: rtl/rx_fifo_handshake.sv
// Receive-side intake: a four-phase valid/ready handshake fills a DEPTH-entry packet FIFO, and the core pops with rc_ready.
// Latency is one cycle for write and for pop. RX_Data_Ready is low while holding or when full, and there is no bypass.
module rx_fifo_handshake #(
  parameter int WIDTH = 55,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       RX_Data_Valid,
  input  logic [WIDTH-1:0]           RX_Data,
  output logic                       RX_Data_Ready,
  input  logic                       rc_ready,
  input  logic                       flush,
  output logic                       rx_has_data,
  output logic [WIDTH-1:0]           rx_data,
  output logic [$clog2(DEPTH+1)-1:0] rx_count,
  output logic                       rx_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {ST_RST, ST_WAIT, ST_HOLD} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [WIDTH-1:0]       mem_d [DEPTH];
  logic                   push;
  logic                   pop;
  logic                   ready;

  assign rx_count      = count_q;
  assign rx_full       = (count_q == CW'(DEPTH));
  assign rx_has_data   = (count_q != '0);
  assign rx_data       = mem_q[rd_ptr_q];
  assign RX_Data_Ready = ready;

  // One write per valid pulse: HOLD waits for the receiver to drop valid.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    push    = 1'b0;
    case (state_q)
      ST_RST:  state_d = ST_WAIT;
      ST_WAIT: begin
        ready = !rx_full;
        if (RX_Data_Valid && !rx_full) begin
          push    = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!RX_Data_Valid) state_d = ST_WAIT;
      end
      default: state_d = ST_RST;
    endcase
  end

  assign pop = rc_ready && rx_has_data;

  // Flush wins over push and pop; a packet accepted during a flush is dropped.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = RX_Data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RST;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_rx_fifo_handshake.sv
// Directed bench for rx_fifo_handshake: inputs change and outputs are sampled on the falling edge.
module tb_rx_fifo_handshake;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX_Data_Valid;
  logic [54:0] RX_Data;
  logic        RX_Data_Ready;
  logic        rc_ready;
  logic        flush;
  logic        rx_has_data;
  logic [54:0] rx_data;
  logic [2:0]  rx_count;
  logic        rx_full;

  int total = 0;
  int bad   = 0;
  logic [54:0] model_q [$];

  rx_fifo_handshake #(.WIDTH(55), .DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .RX_Data_Valid (RX_Data_Valid),
    .RX_Data       (RX_Data),
    .RX_Data_Ready (RX_Data_Ready),
    .rc_ready      (rc_ready),
    .flush         (flush),
    .rx_has_data   (rx_has_data),
    .rx_data       (rx_data),
    .rx_count      (rx_count),
    .rx_full       (rx_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on a falling edge with the intake back in WAIT.
  task automatic push_pkt(input logic [54:0] d);
    int n;
    n = 0;
    RX_Data       = d;
    RX_Data_Valid = 1'b1;
    while (!RX_Data_Ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("push_timeout", 64'd0, 64'd1);
    @(negedge clk);
    RX_Data_Valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_chk(input string tag, input logic [54:0] exp);
    chk(tag, 64'(rx_data), 64'(exp));
    rc_ready = 1'b1;
    @(negedge clk);
    rc_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; RX_Data_Valid = 1'b0; RX_Data = '0; rc_ready = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(RX_Data_Ready), 64'd0);
    chk("rst_has",   64'(rx_has_data),   64'd0);
    chk("rst_full",  64'(rx_full),       64'd0);
    chk("rst_data",  64'(rx_data),       64'd0);
    chk("rst_count", 64'(rx_count),      64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 64'(RX_Data_Ready), 64'd1);
    chk("rel_has",   64'(rx_has_data),   64'd0);

    // Single packet, valid held for 10 cycles
    RX_Data = 55'h1234; RX_Data_Valid = 1'b1;
    @(negedge clk);
    chk("one_count", 64'(rx_count),      64'd1);
    chk("one_data",  64'(rx_data),       64'h1234);
    chk("one_ready", 64'(RX_Data_Ready), 64'd0);
    repeat (9) @(negedge clk);
    chk("hold_count", 64'(rx_count),      64'd1);
    chk("hold_ready", 64'(RX_Data_Ready), 64'd0);
    RX_Data_Valid = 1'b0;
    @(negedge clk);
    chk("drop_ready", 64'(RX_Data_Ready), 64'd1);
    pop_chk("one_pop", 55'h1234);
    chk("one_empty", 64'(rx_has_data), 64'd0);
    chk("one_cnt0",  64'(rx_count),    64'd0);

    // Fill to full, then free a slot with a 5th packet waiting
    for (int i = 1; i <= 4; i++) push_pkt(55'(i));
    chk("full_flag",  64'(rx_full),       64'd1);
    chk("full_count", 64'(rx_count),      64'd4);
    chk("full_ready", 64'(RX_Data_Ready), 64'd0);
    RX_Data = 55'd5; RX_Data_Valid = 1'b1;
    @(negedge clk);
    chk("blk_ready", 64'(RX_Data_Ready), 64'd0);
    chk("blk_count", 64'(rx_count),      64'd4);
    rc_ready = 1'b1;
    @(negedge clk);
    rc_ready = 1'b0;
    chk("free_head",  64'(rx_data),       64'd2);
    chk("free_count", 64'(rx_count),      64'd3);
    chk("free_ready", 64'(RX_Data_Ready), 64'd1);
    @(negedge clk);
    chk("fifth_count", 64'(rx_count),      64'd4);
    chk("fifth_ready", 64'(RX_Data_Ready), 64'd0);
    RX_Data_Valid = 1'b0;
    @(negedge clk);
    for (int i = 2; i <= 5; i++) pop_chk("drain_a", 55'(i));
    chk("drain_a_cnt", 64'(rx_count), 64'd0);

    // Interleaved push/pop across a pointer wrap
    for (int i = 1; i <= 10; i++) begin
      push_pkt(55'(i));
      model_q.push_back(55'(i));
      chk("wrap_count", 64'(rx_count), 64'(model_q.size()));
      if (i % 2 == 0 || model_q.size() == 4) pop_chk("wrap_pop", model_q.pop_front());
    end
    while (model_q.size() > 0) pop_chk("wrap_drain", model_q.pop_front());
    chk("wrap_empty", 64'(rx_has_data), 64'd0);

    // Simultaneous push and pop at count 1
    push_pkt(55'hAA);
    RX_Data = 55'hBB; RX_Data_Valid = 1'b1; rc_ready = 1'b1;
    @(negedge clk);
    rc_ready = 1'b0;
    chk("sim_count", 64'(rx_count), 64'd1);
    chk("sim_head",  64'(rx_data),  64'hBB);
    RX_Data_Valid = 1'b0;
    @(negedge clk);
    pop_chk("sim_pop", 55'hBB);

    // Pop while empty is ignored, including alongside a push into empty
    rc_ready = 1'b1;
    @(negedge clk);
    rc_ready = 1'b0;
    chk("epop_count", 64'(rx_count),      64'd0);
    chk("epop_has",   64'(rx_has_data),   64'd0);
    chk("epop_ready", 64'(RX_Data_Ready), 64'd1);
    RX_Data = 55'hCC; RX_Data_Valid = 1'b1; rc_ready = 1'b1;
    @(negedge clk);
    rc_ready = 1'b0;
    chk("nobyp_count", 64'(rx_count), 64'd1);
    chk("nobyp_head",  64'(rx_data),  64'hCC);
    RX_Data_Valid = 1'b0;
    @(negedge clk);
    pop_chk("nobyp_pop", 55'hCC);

    // Flush with three stored and a concurrent push and pop
    push_pkt(55'h11); push_pkt(55'h22); push_pkt(55'h33);
    chk("pre_flush", 64'(rx_count), 64'd3);
    RX_Data = 55'h44; RX_Data_Valid = 1'b1; flush = 1'b1; rc_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; rc_ready = 1'b0;
    chk("fl_count", 64'(rx_count),      64'd0);
    chk("fl_has",   64'(rx_has_data),   64'd0);
    chk("fl_ready", 64'(RX_Data_Ready), 64'd0);
    RX_Data_Valid = 1'b0;
    @(negedge clk);
    chk("fl_rdy2", 64'(RX_Data_Ready), 64'd1);
    push_pkt(55'h55);
    chk("fl_after_cnt",  64'(rx_count), 64'd1);
    chk("fl_after_head", 64'(rx_data),  64'h55);

    // Reset asserted in HOLD with packets stored
    RX_Data = 55'h66; RX_Data_Valid = 1'b1;
    @(negedge clk);
    chk("hold_rdy", 64'(RX_Data_Ready), 64'd0);
    chk("hold_cnt", 64'(rx_count),      64'd2);
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", 64'(RX_Data_Ready), 64'd0);
    chk("mrst_count", 64'(rx_count),      64'd0);
    chk("mrst_has",   64'(rx_has_data),   64'd0);
    chk("mrst_data",  64'(rx_data),       64'd0);
    @(negedge clk);
    RX_Data_Valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_rel_rdy", 64'(RX_Data_Ready), 64'd1);
    chk("mrst_rel_cnt", 64'(rx_count),      64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_fifo_handshake.md
# rx_fifo_handshake

Parametrised receive-side handshake with packet buffering, placed between the serial `receiver` and the router core. It accepts packets from the receiver over a four-phase valid/ready handshake and stores them in a DEPTH-entry FIFO. The head packet is presented to the router core with `rx_has_data`, and the core pops it with a one-cycle `rc_ready` pulse. The receiver can therefore keep delivering while the core is busy, up to DEPTH packets.

## Interface
- `WIDTH`, 55: packet width in bits.
- `DEPTH`, 4: FIFO depth in packets; must be a power of two, ≥ 2.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `RX_Data_Valid` input 1: receiver has a packet on `RX_Data`; synchronous to `clk`; held high until the receiver sees `RX_Data_Ready` drop.
- `RX_Data` input WIDTH: packet from the receiver; stable while `RX_Data_Valid` is high.
- `RX_Data_Ready` output 1: the block can take a packet.
- `rc_ready` input 1: router core pop strobe, one cycle.
- `flush` input 1: synchronous FIFO clear.
- `rx_has_data` output 1: FIFO not empty.
- `rx_data` output WIDTH: head packet; valid while `rx_has_data` is high.
- `rx_count` output $clog2(DEPTH+1): number of packets stored.
- `rx_full` output 1: `rx_count` == DEPTH.

## Operation
- Intake FSM has three states: RST, WAIT, HOLD.
  - RST: `RX_Data_Ready`=0. Moves unconditionally to WAIT on the first clock after `rst_n` deasserts.
  - WAIT: `RX_Data_Ready` = !`rx_full`. If `RX_Data_Valid` && !`rx_full`, write `RX_Data` at the write pointer and go to HOLD. Otherwise stay in WAIT.
  - HOLD: `RX_Data_Ready`=0. Stay while `RX_Data_Valid`=1; go to WAIT when it is 0.
  - Each valid pulse therefore writes exactly one packet, however long `RX_Data_Valid` stays high.
- Pop: on a clock edge with `rc_ready` && `rx_has_data`, the read pointer advances and `rx_count` decrements.
  - `rc_ready` while empty is ignored.
  - `rc_ready` held high pops once per cycle.
- Push and pop in the same cycle: `rx_count` is unchanged and both pointers advance.
  - No bypass. A push into an empty FIFO is not visible until the next cycle, so a simultaneous pop is ignored.
- Full: `RX_Data_Ready` is held 0 in WAIT and the packet waits at the receiver. A pop while full frees the slot, and the push happens on the following edge. Overflow is impossible by construction.
- Flush: pointers and `rx_count` go to 0 on the edge.
  - Flush takes priority over a same-cycle push and pop. A packet arriving in that cycle is discarded, but the FSM still goes to HOLD so the handshake completes.
  - Storage contents are not cleared.
- Pointers are $clog2(DEPTH) bits and wrap naturally. `rx_count` is tracked separately to tell full from empty.
- `rx_data` = mem[read pointer], read combinationally from the register array.
- Reset values (asynchronous on `rst_n` low):
  - FSM state = RST, pointers = 0, `rx_count` = 0, all storage = 0.
  - Outputs: `RX_Data_Ready`=0, `rx_has_data`=0, `rx_full`=0, `rx_data`=0.
- Reset asserted mid-handshake or with packets stored: everything returns to reset values immediately and all stored packets are lost.

## Timing
- `RX_Data_Ready` goes to 1 one cycle after `rst_n` deasserts (RST→WAIT).
- Write latency: a packet written at edge N gives `rx_has_data`=1, `rx_data` = that packet and `rx_count` +1 after edge N.
- `RX_Data_Ready` falls after edge N and stays 0 until the cycle after `RX_Data_Valid` is seen low.
- Minimum intake period is 2 cycles per packet (valid high for 1 cycle, then low for 1 cycle).
- Pop latency: `rc_ready` sampled at edge M updates `rx_data`, `rx_count` and `rx_has_data` after edge M.
- `rx_full` and `rx_has_data` are decoded from the registered `rx_count`, with no extra cycle of delay.

## Test plan
- Reset, then release:
  - During reset all outputs are 0.
  - One cycle after `rst_n`=1, `RX_Data_Ready`=1 and `rx_has_data`=0.
- Single packet:
  - `RX_Data`=55'h1234 with valid held high for 10 cycles gives exactly one write: `rx_count`=1, `rx_data`=55'h1234, `RX_Data_Ready`=0 until valid drops.
  - A 1-cycle `rc_ready` pulse then gives `rx_has_data`=0 and `rx_count`=0.
- Fill to DEPTH=4:
  - Push packets 1..4 with no pops: `rx_full`=1, `rx_count`=4, `RX_Data_Ready`=0 in WAIT.
  - Offer a 5th packet, then pop once: `rx_data`=2 and the 5th packet is written on the next edge.
- Ordering and wrap-around: push/pop 10 packets interleaved across a full pointer wrap; data pops in FIFO order 1..10 with `rx_count` never above 4.
- Simultaneous push and pop at `rx_count`=1: count stays 1 and head becomes the new packet.
- Empty-pop, flush and mid-reset:
  - `rc_ready` while empty changes nothing.
  - `flush` with 3 stored packets and a concurrent push gives `rx_count`=0 and the packet is discarded.
  - `rst_n` low while in HOLD gives `RX_Data_Ready`=0 immediately.
